// File: rtl/dequant_expand_if.sv
// Beat-level handshake bundle for dequant_expand: packed int8 lanes in, packed int32 lanes out.
interface dequant_expand_if #(
    parameter int LANES = 2
);
    // A beat transfers on a rising edge where valid && ready; the source holds its
    // beat until then, and the sink may raise or drop ready at any time.
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*8-1:0]    data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*32-1:0]   data_out;

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );
endinterface

// File: rtl/dequant_expand.sv
// Two-stage int8 -> int32 dequantizer: per-lane multiply by a signed scale, then round-half-up
// arithmetic right shift. Define DEQUANT_ZP_EN to add a per-beat zero-point subtraction (cfg_zp).
module dequant_expand #(
    parameter int LANES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic signed [15:0] cfg_scale,
    input  logic [4:0]         cfg_shift,
`ifdef DEQUANT_ZP_EN
    input  logic signed [7:0]  cfg_zp,
`endif
    dequant_expand_if.slave    bus
);

`ifdef DEQUANT_ZP_EN
    localparam int         PW   = 25;
    localparam logic [4:0] SMAX = 5'd24;
`else
    localparam int         PW   = 24;
    localparam logic [4:0] SMAX = 5'd23;
`endif
    localparam logic signed [PW:0] ONE_W = 1;

    logic signed [15:0]        scale_r;
    logic [4:0]                shift_r;
`ifdef DEQUANT_ZP_EN
    logic signed [7:0]         zp_r;
`endif

    logic                      s1_valid;
    logic [LANES-1:0][PW-1:0]  s1_p;
    logic [4:0]                s1_shift;

    logic                      s2_adv;
    logic                      s1_adv;
    logic                      accept;
    logic [LANES-1:0][PW-1:0]  prod;
    logic [LANES-1:0][PW:0]    sum_v;
    logic [LANES-1:0][PW:0]    shr_v;
    logic signed [PW:0]        rnd;
    logic [LANES*32-1:0]       y;

    assign s2_adv      = !bus.out_valid || bus.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign accept      = bus.in_valid && s1_adv;

    // Products never exceed PW signed bits, so the truncating PW-bit multiply is exact.
    always_comb begin
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef DEQUANT_ZP_EN
            prod[i] = (PW'($signed(bus.data_in[8*i +: 8])) - PW'(zp_r)) * PW'(scale_r);
`else
            prod[i] = PW'($signed(bus.data_in[8*i +: 8])) * PW'(scale_r);
`endif
        end
    end

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    always_comb begin
        rnd   = '0;
        sum_v = '0;
        shr_v = '0;
        y     = '0;
        if (s1_shift != 5'd0) begin
            rnd = ONE_W << (s1_shift - 5'd1);
        end
        for (int i = 0; i < LANES; i++) begin
            sum_v[i]      = $signed({s1_p[i][PW-1], s1_p[i]}) + rnd;
            shr_v[i]      = $signed(sum_v[i]) >>> s1_shift;
            y[32*i +: 32] = 32'($signed(shr_v[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_r      <= 16'sd1;
            shift_r      <= '0;
`ifdef DEQUANT_ZP_EN
            zp_r         <= '0;
`endif
            s1_valid     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            if (cfg_we) begin
                scale_r <= cfg_scale;
                shift_r <= (cfg_shift > SMAX) ? SMAX : cfg_shift;
`ifdef DEQUANT_ZP_EN
                zp_r    <= cfg_zp;
`endif
            end
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.data_out <= y;
                end
            end
        end
    end

    // Shift travels with its product so later config writes cannot touch in-flight beats.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p     <= prod;
            s1_shift <= shift_r;
        end
    end

endmodule

// File: tb/tb_dequant_expand.sv
// Bench for dequant_expand: vector table, hand-written corner sequences, and random traffic
// checked by an arithmetic reference model with a FIFO of expected beats.
module tb_dequant_expand;

    localparam int LANES = 2;
`ifdef DEQUANT_ZP_EN
    localparam int SMAX = 24;
    localparam logic [31:0] CLAMP_E0 = 32'h0;
`else
    localparam int SMAX = 23;
    localparam logic [31:0] CLAMP_E0 = 32'h1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_scale = '0;
    logic [4:0]  cfg_shift = '0;
`ifdef DEQUANT_ZP_EN
    logic [7:0]  cfg_zp = '0;
`endif

    dequant_expand_if #(.LANES(LANES)) bus ();

    dequant_expand #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_scale (cfg_scale),
        .cfg_shift (cfg_shift),
`ifdef DEQUANT_ZP_EN
        .cfg_zp    (cfg_zp),
`endif
        .bus       (bus.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_lane(input int x, input int zp, input int scale, input int sh);
        longint p, d, n, q;
        p = longint'(x - zp) * longint'(scale);
        if (sh == 0) return 32'(p);
        d = longint'(1) << sh;
        n = p + d / 2;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return 32'(q);
    endfunction

    int m_scale = 1;
    int m_shift = 0;
    int m_zp    = 0;
    int cyc     = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];

    function automatic logic [63:0] model_beat(input logic [15:0] din);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[32*i +: 32] = ref_lane(int'($signed(din[8*i +: 8])), m_zp, m_scale, m_shift);
        return r;
    endfunction

    // Scoreboard: sampled 2 time units after each falling edge, predicting the next rising edge.
    // A beat is visible two cycles after the cycle in which it was accepted; capacity is two beats.
    always @(negedge clk) begin
        logic exp_v;
        #2;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            m_scale = 1;
            m_shift = 0;
            m_zp    = 0;
        end else begin
            exp_v = (exp_q.size() > 0) && (cyc >= acc_q[0] + 2);
            check("mon_out_valid", 64'(bus.out_valid), 64'(exp_v));
            check("mon_in_ready", 64'(bus.in_ready),
                  64'(!((exp_q.size() == 2) && !bus.out_ready)));
            if (exp_v && bus.out_valid) check("mon_data_out", bus.data_out, exp_q[0]);
            if (exp_v && bus.out_valid && bus.out_ready) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_beat(bus.data_in));
                acc_q.push_back(cyc);
            end
            if (cfg_we) begin
                m_scale = int'($signed(cfg_scale));
                m_shift = (int'(cfg_shift) > SMAX) ? SMAX : int'(cfg_shift);
`ifdef DEQUANT_ZP_EN
                m_zp    = int'($signed(cfg_zp));
`endif
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [15:0] sc, input logic [4:0] sh);
        @(negedge clk);
        cfg_we = 1'b1; cfg_scale = sc; cfg_shift = sh;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = d;
        #1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic expect_beat(input string name, input logic [63:0] exp);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
        end else begin
            check(name, bus.data_out, exp);
        end
        @(negedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk); n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic [15:0] scale;
        logic [4:0]  shift;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vec[8];

    initial begin
        int sent, guard, ph;

        vec[0] = '{8'h7F, 8'h80, 16'h0001, 5'd0,  32'h0000007F, 32'hFFFFFF80};
        vec[1] = '{8'h01, 8'hFF, 16'h0003, 5'd1,  32'h00000002, 32'hFFFFFFFF};
        vec[2] = '{8'h80, 8'h80, 16'h8000, 5'd0,  32'h00400000, 32'h00400000};
        vec[3] = '{8'h07, 8'hF9, 16'h0005, 5'd2,  32'h00000009, 32'hFFFFFFF7};
        vec[4] = '{8'h01, 8'hFF, 16'h0001, 5'd1,  32'h00000001, 32'h00000000};
        vec[5] = '{8'h80, 8'h00, 16'hFFFF, 5'd0,  32'h00000080, 32'h00000000};
        vec[6] = '{8'h80, 8'h7F, 16'h8000, 5'd31, CLAMP_E0,     32'h00000000};
        vec[7] = '{8'h7F, 8'h80, 16'h7FFF, 5'd7,  32'h00007EFF, 32'hFFFF8001};

        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_data_out",  bus.data_out,        64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_data_out",  bus.data_out,        64'd0);

        // ---- table vectors ----
        for (int i = 0; i < 8; i++) begin
            set_cfg(vec[i].scale, vec[i].shift);
            send({vec[i].x1, vec[i].x0});
            idle();
            expect_beat($sformatf("vec%0d", i), {vec[i].e1, vec[i].e0});
        end

        // ---- config hazard: cfg_we in the accept cycle of A affects only B ----
        set_cfg(16'd1, 5'd0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = {8'hFB, 8'h07};
        cfg_we = 1'b1; cfg_scale = 16'd2; cfg_shift = 5'd0;
        @(negedge clk);
        bus.data_in = {8'h03, 8'h09};
        cfg_we = 1'b0;
        idle();
        expect_beat("hazard_a_scale1", {32'hFFFFFFFB, 32'h00000007});
        expect_beat("hazard_b_scale2", {32'h00000006, 32'h00000012});

        // ---- shift changed while C sits in S1 ----
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = {8'hFD, 8'h05};
        @(negedge clk);
        bus.in_valid = 1'b0;
        cfg_we = 1'b1; cfg_scale = 16'd2; cfg_shift = 5'd1;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("hazard_c_valid", 64'(bus.out_valid), 64'd1);
        check("hazard_c_old_shift", bus.data_out, {32'hFFFFFFFA, 32'h0000000A});
        send({8'hFD, 8'h05});
        idle();
        expect_beat("hazard_d_new_shift", {32'hFFFFFFFD, 32'h00000005});

        // ---- backpressure: 10 incrementing beats, out_ready 1-0-0 ----
        sent = 0; guard = 0; ph = 0;
        while (sent < 10 && guard < 200) begin
            @(negedge clk);
            bus.out_ready = (ph % 3 == 0);
            ph++;
            bus.in_valid = 1'b1;
            bus.data_in  = {8'(sent * 3), 8'(sent)};
            #1;
            if (bus.in_ready) sent++;
            guard++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && guard < 260) begin
            bus.out_ready = (ph % 3 == 0);
            ph++;
            @(negedge clk);
            guard++;
        end
        bus.out_ready = 1'b1;
        drain();

        // ---- random traffic ----
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.data_in   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cfg_we        = ($urandom_range(0, 19) == 0);
            cfg_scale     = 16'($urandom);
            cfg_shift     = 5'($urandom_range(0, 31));
`ifdef DEQUANT_ZP_EN
            cfg_zp        = 8'($urandom);
`endif
        end
        @(negedge clk);
        bus.in_valid = 1'b0; cfg_we = 1'b0; bus.out_ready = 1'b1;
        drain();

        // ---- async reset with both stages full ----
        bus.out_ready = 1'b0;
        send({8'h11, 8'h22});
        send({8'h33, 8'h44});
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("full_in_ready",  64'(bus.in_ready),  64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_data_out",  bus.data_out,        64'd0);
        check("async_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check("no_stale_beat", 64'(bus.out_valid), 64'd0);
        end
        send({8'hFB, 8'h07});
        idle();
        expect_beat("post_reset_default_cfg", {32'hFFFFFFFB, 32'h00000007});

`ifdef DEQUANT_ZP_EN
        // ---- zero point ----
        @(negedge clk);
        cfg_we = 1'b1; cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_zp = 8'd10;
        @(negedge clk);
        cfg_we = 1'b0;
        send(16'h0000);
        idle();
        expect_beat("zp_minus10", {32'hFFFFFFF6, 32'hFFFFFFF6});
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "global timeout");
    end

endmodule
